// File: rtl/button_setpoint_ctrl.sv
// Saturating setpoint register driven by debounced active-low up/down buttons.
// One step per press, auto-repeat after a hold delay, lockout on conflicting or disabled presses.
module button_setpoint_ctrl #(
  parameter int WIDTH         = 16,
  parameter int SP_MIN        = 0,
  parameter int SP_MAX        = 1000,
  parameter int SP_INIT       = 100,
  parameter int STEP          = 1,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_btn_up,
  input  logic             i_btn_dn,
  output logic [WIDTH-1:0] o_setpoint,
  output logic             o_changed,
  output logic             o_at_min,
  output logic             o_at_max
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  localparam logic [WIDTH:0]   MIN_X       = (WIDTH+1)'(SP_MIN);
  localparam logic [WIDTH:0]   MAX_X       = (WIDTH+1)'(SP_MAX);
  localparam logic [WIDTH:0]   STEP_X      = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] INIT_W      = WIDTH'(SP_INIT);
  localparam logic [WIDTH-1:0] MIN_W       = WIDTH'(SP_MIN);
  localparam logic [WIDTH-1:0] MAX_W       = WIDTH'(SP_MAX);
  localparam logic [31:0]      HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0]      REPEAT_LAST = 32'(REPEAT_CYCLES - 1);

  state_t           state_q;
  logic [31:0]      cnt_q;
  logic             dir_up_q;
  logic [WIDTH-1:0] setpoint_q;
  logic             changed_q;

  logic             up_act, dn_act, active, other;
  logic [WIDTH:0]   sp_x, up_sum;
  logic [WIDTH-1:0] up_new, dn_new, idle_new, held_new;
  logic [31:0]      period_last;

  // Saturating arithmetic in WIDTH+1 bits so neither direction can wrap.
  always_comb begin
    sp_x   = {1'b0, setpoint_q};
    up_sum = sp_x + STEP_X;
    up_new = (up_sum > MAX_X) ? MAX_W : up_sum[WIDTH-1:0];
    dn_new = (sp_x < MIN_X + STEP_X) ? MIN_W : setpoint_q - STEP_X[WIDTH-1:0];
  end

  assign up_act      = ~i_btn_up;
  assign dn_act      = ~i_btn_dn;
  assign active      = dir_up_q ? up_act : dn_act;
  assign other       = dir_up_q ? dn_act : up_act;
  assign idle_new    = up_act ? up_new : dn_new;
  assign held_new    = dir_up_q ? up_new : dn_new;
  assign period_last = (state_q == HOLD) ? HOLD_LAST : REPEAT_LAST;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= LOCK;
      cnt_q      <= '0;
      dir_up_q   <= 1'b1;
      setpoint_q <= INIT_W;
      changed_q  <= 1'b0;
    end else begin
      changed_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (up_act && dn_act) begin
            state_q <= LOCK;
          end else if (up_act || dn_act) begin
            if (!i_enable) begin
              state_q <= LOCK;
            end else begin
              state_q    <= HOLD;
              dir_up_q   <= up_act;
              setpoint_q <= idle_new;
              changed_q  <= (idle_new != setpoint_q);
            end
          end
        end
        HOLD, REPEAT: begin
          // Release wins over a conflicting press so the next press starts from IDLE.
          if (!active) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (other || !i_enable) begin
            state_q <= LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == period_last) begin
            state_q    <= REPEAT;
            cnt_q      <= '0;
            setpoint_q <= held_new;
            changed_q  <= (held_new != setpoint_q);
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: begin
          cnt_q <= '0;
          if (!up_act && !dn_act) state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_setpoint = setpoint_q;
  assign o_changed  = changed_q;
  assign o_at_min   = (setpoint_q == MIN_W);
  assign o_at_max   = (setpoint_q == MAX_W);

endmodule
